// File: rtl/jk_arb_ctrl.sv
// Arbiter that time-shares one external master-slave JK flip-flop among NREQ requesters.
// Round-robin by default; define JK_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module jk_arb_ctrl #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   cmd,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic                rdata,
    output logic                jj,
    output logic                kk,
    output logic                ff_clk,
    input  logic                qq,
    input  logic                qqbar,
    output logic                busy,
    output logic                err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_next;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   w_ack_next;
    logic              r_rdata;
    logic              w_rdata_next;
    logic              r_jj;
    logic              w_jj_next;
    logic              r_kk;
    logic              w_kk_next;
    logic              r_ff_clk;
    logic              w_ff_clk_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_err;
    logic              w_err_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;

    logic              w_found;
    logic [IW-1:0]     w_win_idx;
    logic [IW-1:0]     w_cand;
    logic [NREQ-1:0]   w_win_oh;
    logic [NREQ-1:0]   w_j_vec;
    logic [NREQ-1:0]   w_k_vec;
    logic              w_win_j;
    logic              w_win_k;

`ifndef JK_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     w_ptr_next;
    logic [IW-1:0]     w_ptr_adv;
    logic [IW:0]       w_sum;
    logic [IW:0]       w_adv;
`endif

    // Winner search: walk requesters starting from the pointer (or index 0), first hit wins.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
`ifndef JK_ARB_FIXED_PRIO_EN
        w_sum     = '0;
        w_adv     = '0;
        w_ptr_adv = '0;
`endif
        for (int off = 0; off < NREQ; off++) begin
`ifdef JK_ARB_FIXED_PRIO_EN
            w_cand = IW'(off);
`else
            w_sum = {1'b0, r_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_cand = w_sum[IW-1:0];
`endif
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
`ifndef JK_ARB_FIXED_PRIO_EN
        w_adv = {1'b0, w_win_idx} + (IW+1)'(1);
        if (w_adv >= (IW+1)'(NREQ)) begin
            w_adv = '0;
        end
        w_ptr_adv = w_adv[IW-1:0];
`endif
    end

    // One-hot winner decode and AND-OR selection of the winner's {j,k}.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign w_win_oh[gi] = (w_win_idx == IW'(gi));
            assign w_j_vec[gi]  = cmd[2*gi+1];
            assign w_k_vec[gi]  = cmd[2*gi];
        end
    endgenerate

    assign w_win_j = |(w_win_oh & w_j_vec);
    assign w_win_k = |(w_win_oh & w_k_vec);

    always_comb begin
        w_state_next  = r_state;
        w_gnt_next    = r_gnt;
        w_ack_next    = '0;
        w_rdata_next  = r_rdata;
        w_jj_next     = r_jj;
        w_kk_next     = r_kk;
        w_ff_clk_next = 1'b0;
        w_err_next    = r_err;
        w_cnt_next    = r_cnt;
`ifndef JK_ARB_FIXED_PRIO_EN
        w_ptr_next    = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_next = '0;
                w_jj_next  = 1'b0;
                w_kk_next  = 1'b0;
                if (w_found) begin
                    w_state_next  = DRIVE;
                    w_gnt_next    = w_win_oh;
                    w_jj_next     = w_win_j;
                    w_kk_next     = w_win_k;
                    w_ff_clk_next = 1'b1;
`ifndef JK_ARB_FIXED_PRIO_EN
                    w_ptr_next    = w_ptr_adv;
`endif
                end
            end
            DRIVE: begin
                w_state_next = SETTLE;
                w_cnt_next   = '0;
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    // q is sampled on the edge entering DONE so rdata lines up with ack.
                    w_state_next = DONE;
                    w_rdata_next = qq;
                    w_ack_next   = r_gnt;
                    if (qq == qqbar) begin
                        w_err_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
                w_jj_next    = 1'b0;
                w_kk_next    = 1'b0;
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rdata  <= 1'b0;
            r_jj     <= 1'b0;
            r_kk     <= 1'b0;
            r_ff_clk <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_gnt    <= w_gnt_next;
            r_ack    <= w_ack_next;
            r_rdata  <= w_rdata_next;
            r_jj     <= w_jj_next;
            r_kk     <= w_kk_next;
            r_ff_clk <= w_ff_clk_next;
            r_busy   <= w_busy_next;
            r_err    <= w_err_next;
            r_cnt    <= w_cnt_next;
        end
    end

`ifndef JK_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign rdata  = r_rdata;
    assign jj     = r_jj;
    assign kk     = r_kk;
    assign ff_clk = r_ff_clk;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule

// File: tb/tb_jk_arb_ctrl.sv
// Directed bench for jk_arb_ctrl (NREQ=4, SETTLE_CYC=2) with a behavioural JK flip-flop.
// Contention expectations follow JK_ARB_FIXED_PRIO_EN when it is defined.
module tb_jk_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] cmd;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       rdata;
    logic       jj;
    logic       kk;
    logic       ff_clk;
    logic       qq;
    logic       qqbar;
    logic       busy;
    logic       err;

    logic       q_model = 1'b0;
    logic       fault;
    int         n_pass  = 0;
    int         n_total = 0;

    jk_arb_ctrl #(.NREQ(4), .SETTLE_CYC(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .cmd    (cmd),
        .gnt    (gnt),
        .ack    (ack),
        .rdata  (rdata),
        .jj     (jj),
        .kk     (kk),
        .ff_clk (ff_clk),
        .qq     (qq),
        .qqbar  (qqbar),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Master-slave JK: output changes when the strobe falls.
    always @(negedge ff_clk) begin
        case ({jj, kk})
            2'b01:   q_model <= 1'b0;
            2'b10:   q_model <= 1'b1;
            2'b11:   q_model <= ~q_model;
            default: q_model <= q_model;
        endcase
    end

    assign qq    = fault ? 1'b1 : q_model;
    assign qqbar = fault ? 1'b1 : ~q_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Called in the IDLE cycle whose closing edge sees req; returns in the IDLE cycle after DONE.
    task automatic run_txn(input string tag, input logic [3:0] exp_gnt, input logic exp_j,
                           input logic exp_k, input logic exp_rd, input logic [3:0] mid_req,
                           input logic [3:0] done_req);
        logic [7:0] c_orig;
        logic [3:0] seen_ack;
        logic       seen_rd;
        c_orig = cmd;
        tick();
        chk({tag, ".drive_gnt"}, 8'(gnt), 8'(exp_gnt));
        chk({tag, ".drive_ffclk"}, 8'(ff_clk), 8'd1);
        chk({tag, ".drive_jk"}, 8'({jj, kk}), 8'({exp_j, exp_k}));
        chk({tag, ".drive_busy"}, 8'(busy), 8'd1);
        chk({tag, ".drive_ack"}, 8'(ack), 8'd0);
        tick();
        chk({tag, ".settle1_ffclk"}, 8'(ff_clk), 8'd0);
        chk({tag, ".settle1_gnt"}, 8'(gnt), 8'(exp_gnt));
        chk({tag, ".settle1_ack"}, 8'(ack), 8'd0);
        req = mid_req;
        cmd = ~c_orig;
        tick();
        chk({tag, ".settle2_jk"}, 8'({jj, kk}), 8'({exp_j, exp_k}));
        chk({tag, ".settle2_gnt"}, 8'(gnt), 8'(exp_gnt));
        chk({tag, ".settle2_ack"}, 8'(ack), 8'd0);
        tick();
        // Counting the IDLE cycle as the first, ack lands in the fifth cycle.
        seen_ack = ack;
        seen_rd  = rdata;
        chk({tag, ".done_ack"}, 8'(ack), 8'(exp_gnt));
        chk({tag, ".done_rdata"}, 8'(rdata), 8'(exp_rd));
        chk({tag, ".done_gnt"}, 8'(gnt), 8'(exp_gnt));
        cmd = c_orig;
        req = done_req;
        tick();
        chk({tag, ".idle_gnt"}, 8'(gnt), 8'd0);
        chk({tag, ".idle_ack"}, 8'(ack), 8'd0);
        chk({tag, ".idle_busy"}, 8'(busy), 8'd0);
        chk({tag, ".idle_jk"}, 8'({jj, kk}), 8'd0);
        $display("txn %s gnt=%b ack=%b rdata=%b err=%b", tag, exp_gnt, seen_ack, seen_rd, err);
    endtask

    logic [3:0] exp_cont [5];
    logic       exp_cont_rd [5];

    initial begin
`ifdef JK_ARB_FIXED_PRIO_EN
        exp_cont = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_cont = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        exp_cont_rd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        req   = 4'b0000;
        cmd   = 8'h00;
        fault = 1'b0;
        tick();
        tick();
        chk("rst.gnt", 8'(gnt), 8'd0);
        chk("rst.ack", 8'(ack), 8'd0);
        chk("rst.rdata", 8'(rdata), 8'd0);
        chk("rst.jk", 8'({jj, kk}), 8'd0);
        chk("rst.ffclk", 8'(ff_clk), 8'd0);
        chk("rst.busy", 8'(busy), 8'd0);
        chk("rst.err", 8'(err), 8'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_noreq.gnt", 8'(gnt), 8'd0);
        chk("idle_noreq.busy", 8'(busy), 8'd0);

        // Set from q=0
        req = 4'b0001;
        cmd = 8'b00_00_00_10;
        run_txn("single", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000);

        // Requester 2 toggles twice from q=1
        req = 4'b0100;
        cmd = 8'b00_11_00_00;
        run_txn("toggle_a", 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000);
        req = 4'b0100;
        run_txn("toggle_b", 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000);
        chk("no_err_yet", 8'(err), 8'd0);

        // Contention from a fresh pointer; everyone toggles, q starts at 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req = 4'b1111;
        cmd = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("contend%0d", i), exp_cont[i], 1'b1, 1'b1, exp_cont_rd[i],
                    4'b1111, (i == 4) ? 4'b0000 : 4'b1111);
        end

        // Requester 1 withdraws mid-SETTLE while requester 3 arrives late
        req = 4'b0010;
        cmd = 8'b01_00_10_00;
        run_txn("withdraw", 4'b0010, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000);
        run_txn("late_req", 4'b1000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000);

        // Inconsistent qq/qqbar: rdata still follows qq, err latches
        req   = 4'b0001;
        cmd   = 8'h00;
        fault = 1'b1;
        run_txn("fault", 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        chk("fault.err", 8'(err), 8'd1);
        fault = 1'b0;
        tick();
        chk("fault.err_sticky", 8'(err), 8'd1);

        // Reset during DRIVE
        req = 4'b0001;
        cmd = 8'h00;
        tick();
        chk("abort.drive_gnt", 8'(gnt), 8'b0001);
        chk("abort.drive_ffclk", 8'(ff_clk), 8'd1);
        chk("abort.err_held", 8'(err), 8'd1);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        chk("abort.gnt", 8'(gnt), 8'd0);
        chk("abort.ack", 8'(ack), 8'd0);
        chk("abort.rdata", 8'(rdata), 8'd0);
        chk("abort.jk", 8'({jj, kk}), 8'd0);
        chk("abort.ffclk", 8'(ff_clk), 8'd0);
        chk("abort.busy", 8'(busy), 8'd0);
        chk("abort.err", 8'(err), 8'd0);
        tick();
        tick();
        chk("abort.no_ack", 8'(ack), 8'd0);
        rst_n = 1'b1;
        req   = 4'b0100;
        cmd   = 8'b00_10_00_00;
        run_txn("post_reset", 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
